instr_encoder_loader: RTL and testbench

Host-side program loader and the encoder counterpart of the core's instruction decoder. It accepts symbolic instruction commands (operation, register fields, immediate) over a valid/ready handshake. It encodes each command into a 32-bit RV32I word from the supported subset and writes the words sequentially into instruction memory from address 0. When loading is finished it releases the core through cpu_run.

---
 rtl/instr_encoder_loader.sv | 251 +++++++++++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// instr_encoder_loader : encodes symbolic RV32I commands, loads them into imem
// from word 0, then releases the core. Optional macro: NOP_PAD_EN. Rev 1.0
// ============================================================================
module instr_encoder_loader #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              restart,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_op,
   input  logic [4:0]        cmd_rd,
   input  logic [4:0]        cmd_rs1,
   input  logic [4:0]        cmd_rs2,
   input  logic [20:0]       cmd_imm,
   input  logic              cmd_last,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [ADDR_W:0]   words_written,
   output logic              cpu_run,
   output logic              err,
   output logic [1:0]        err_code
);

   localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_COUNT  = (ADDR_W+1)'(1);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_ADDI = 4'd5;
   localparam logic [3:0] OP_LW   = 4'd6;
   localparam logic [3:0] OP_SW   = 4'd7;
   localparam logic [3:0] OP_BEQ  = 4'd8;
   localparam logic [3:0] OP_JAL  = 4'd9;
   localparam logic [3:0] OP_JALR = 4'd10;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] ERR_IMM     = 2'b10;
   localparam logic [1:0] ERR_FULL    = 2'b11;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WRITE = 3'd1;
   localparam logic [2:0] S_DONE  = 3'd2;
   localparam logic [2:0] S_ERROR = 3'd3;
`ifdef NOP_PAD_EN
   localparam logic [2:0] S_PAD   = 3'd4;
   localparam logic [31:0] NOP_WORD = 32'h0000_0013;
`endif

   logic [2:0]        state;
   logic [2:0]        state_nx;
   logic [ADDR_W:0]   count;
   logic [ADDR_W:0]   count_inc;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [1:0]        err_code_q;
   logic              last_q;

   logic              fits12;
   logic              fits13;
   logic              imm_bad;
   logic              op_illegal;
   logic              mem_full;
   logic [1:0]        reject_code;
   logic [2:0]        rtype_funct3;
   logic [6:0]        rtype_funct7;
   logic [31:0]       enc_word;

   assign count_inc  = count + ONE_COUNT;
   assign mem_full   = (count == FULL_COUNT);
   assign op_illegal = (cmd_op > OP_JALR);

   // Range checks on the 21-bit signed immediate: sign bits above the field must agree.
   assign fits12 = (cmd_imm[20:11] == {10{cmd_imm[11]}});
   assign fits13 = (cmd_imm[20:12] == {9{cmd_imm[12]}});

   always_comb begin
      imm_bad = 1'b0;
      case (cmd_op)
         OP_ADDI, OP_LW, OP_SW, OP_JALR: imm_bad = !fits12;
         OP_BEQ:                         imm_bad = !fits13 || cmd_imm[0];
         OP_JAL:                         imm_bad = cmd_imm[0];
         default:                        imm_bad = 1'b0;
      endcase
   end

   always_comb begin
      reject_code = ERR_NONE;
      if (op_illegal)
         reject_code = ERR_ILLEGAL;
      else if (imm_bad)
         reject_code = ERR_IMM;
      else if (mem_full)
         reject_code = ERR_FULL;
   end

   always_comb begin
      rtype_funct3 = 3'b000;
      case (cmd_op)
         OP_AND:  rtype_funct3 = 3'b111;
         OP_OR:   rtype_funct3 = 3'b110;
         OP_XOR:  rtype_funct3 = 3'b100;
         default: rtype_funct3 = 3'b000;
      endcase
      rtype_funct7 = (cmd_op == OP_SUB) ? 7'b0100000 : 7'b0000000;
   end

   always_comb begin
      enc_word = 32'h0;
      case (cmd_op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
            enc_word = {rtype_funct7, cmd_rs2, cmd_rs1, rtype_funct3, cmd_rd, 7'b0110011};
         OP_ADDI:
            enc_word = {cmd_imm[11:0], cmd_rs1, 3'b000, cmd_rd, 7'b0010011};
         OP_LW:
            enc_word = {cmd_imm[11:0], cmd_rs1, 3'b010, cmd_rd, 7'b0000011};
         OP_SW:
            enc_word = {cmd_imm[11:5], cmd_rs2, cmd_rs1, 3'b010, cmd_imm[4:0], 7'b0100011};
         OP_BEQ:
            enc_word = {cmd_imm[12], cmd_imm[10:5], cmd_rs2, cmd_rs1, 3'b000,
                        cmd_imm[4:1], cmd_imm[11], 7'b1100011};
         OP_JAL:
            enc_word = {cmd_imm[20], cmd_imm[10:1], cmd_imm[11], cmd_imm[19:12],
                        cmd_rd, 7'b1101111};
         OP_JALR:
            enc_word = {cmd_imm[11:0], cmd_rs1, 3'b000, cmd_rd, 7'b1100111};
         default:
            enc_word = 32'h0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else if (restart)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (cmd_valid)
               state_nx = (reject_code != ERR_NONE) ? S_ERROR : S_WRITE;
         end
         S_WRITE: begin
            if (!last_q)
               state_nx = S_IDLE;
`ifdef NOP_PAD_EN
            else if (count_inc != FULL_COUNT)
               state_nx = S_PAD;
`endif
            else
               state_nx = S_DONE;
         end
`ifdef NOP_PAD_EN
         S_PAD: begin
            if (count_inc == FULL_COUNT)
               state_nx = S_DONE;
         end
`endif
         S_DONE:  state_nx = S_DONE;
         S_ERROR: state_nx = S_ERROR;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = 1'b0;
      imem_we   = 1'b0;
      cpu_run   = 1'b0;
      err       = 1'b0;
      case (state)
         S_IDLE:  cmd_ready = 1'b1;
         S_WRITE: imem_we   = 1'b1;
`ifdef NOP_PAD_EN
         S_PAD:   imem_we   = 1'b1;
`endif
         S_DONE:  cpu_run   = 1'b1;
         S_ERROR: err       = 1'b1;
         default: cmd_ready = 1'b0;
      endcase
   end

   // Write address/data are registered at accept so the strobe cycle sees stable values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         err_code_q <= ERR_NONE;
         last_q     <= 1'b0;
      end else if (restart) begin
         count      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         err_code_q <= ERR_NONE;
         last_q     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  if (reject_code != ERR_NONE) begin
                     err_code_q <= reject_code;
                  end else begin
                     wdata_q <= enc_word;
                     addr_q  <= count[ADDR_W-1:0];
                     last_q  <= cmd_last;
                  end
               end
            end
            S_WRITE: begin
               count <= count_inc;
`ifdef NOP_PAD_EN
               if (last_q && (count_inc != FULL_COUNT)) begin
                  wdata_q <= NOP_WORD;
                  addr_q  <= count_inc[ADDR_W-1:0];
               end
`endif
            end
`ifdef NOP_PAD_EN
            S_PAD: begin
               count <= count_inc;
               if (count_inc != FULL_COUNT)
                  addr_q <= count_inc[ADDR_W-1:0];
            end
`endif
            default: begin
            end
         endcase
      end
   end

   assign imem_addr     = addr_q;
   assign imem_wdata    = wdata_q;
   assign words_written = count;
   assign err_code      = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// Bench for instr_encoder_loader at DEPTH=4: directed scenarios plus randomized
// programs compared against a behavioural encoder/loader model.
module tb_instr_encoder_loader;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              restart = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [3:0]        cmd_op = '0;
   logic [4:0]        cmd_rd = '0;
   logic [4:0]        cmd_rs1 = '0;
   logic [4:0]        cmd_rs2 = '0;
   logic [20:0]       cmd_imm = '0;
   logic              cmd_last = 1'b0;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic [ADDR_W:0]   words_written;
   logic              cpu_run;
   logic              err;
   logic [1:0]        err_code;

   int errors = 0;
   int checks = 0;
   int          wr_addr_q[$];
   logic [31:0] wr_data_q[$];

   instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .restart(restart),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
      .cmd_last(cmd_last), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .words_written(words_written), .cpu_run(cpu_run),
      .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         wr_addr_q.push_back(int'(imem_addr));
         wr_data_q.push_back(imem_wdata);
      end
   end

   // ---------------- reference model ----------------
   function automatic int fld(int v, int hi, int lo);
      return (v >>> lo) & ((1 << (hi - lo + 1)) - 1);
   endfunction

   function automatic logic [31:0] ref_word(int op, int rd, int rs1, int rs2, int imm);
      int w;
      int f3;
      w  = 0;
      f3 = (op == 2) ? 7 : (op == 3) ? 6 : (op == 4) ? 4 : 0;
      case (op)
         0, 1, 2, 3, 4: w = (((op == 1) ? 32 : 0) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h33;
         5:  w = (fld(imm, 11, 0) << 20) | (rs1 << 15) | (rd << 7) | 'h13;
         6:  w = (fld(imm, 11, 0) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 'h03;
         7:  w = (fld(imm, 11, 5) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12) | (fld(imm, 4, 0) << 7) | 'h23;
         8:  w = (fld(imm, 12, 12) << 31) | (fld(imm, 10, 5) << 25) | (rs2 << 20) | (rs1 << 15)
                 | (fld(imm, 4, 1) << 8) | (fld(imm, 11, 11) << 7) | 'h63;
         9:  w = (fld(imm, 20, 20) << 31) | (fld(imm, 10, 1) << 21) | (fld(imm, 11, 11) << 20)
                 | (fld(imm, 19, 12) << 12) | (rd << 7) | 'h6F;
         10: w = (fld(imm, 11, 0) << 20) | (rs1 << 15) | (rd << 7) | 'h67;
         default: w = 0;
      endcase
      return w;
   endfunction

   function automatic int ref_check(int op, int imm);
      if (op > 10) return 1;
      if (op inside {5, 6, 7, 10}) return (imm < -2048 || imm > 2047) ? 2 : 0;
      if (op == 8) return (imm < -4096 || imm > 4094 || (imm % 2) != 0) ? 2 : 0;
      if (op == 9) return ((imm % 2) != 0) ? 2 : 0;
      return 0;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic do_reset();
      cmd_valid = 1'b0;
      restart   = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      wr_addr_q.delete();
      wr_data_q.delete();
   endtask

   task automatic do_restart();
      cmd_valid = 1'b0;
      @(negedge clk);
      restart = 1'b1;
      @(posedge clk);
      #1 restart = 1'b0;
      wr_addr_q.delete();
      wr_data_q.delete();
   endtask

   task automatic send_cmd(input int op, input int rd, input int rs1, input int rs2,
                           input int imm, input bit last, output bit acc);
      acc = 1'b0;
      for (int i = 0; i < 10 && !acc; i++) begin
         @(negedge clk);
         if (cmd_ready === 1'b1) begin
            cmd_op = op[3:0]; cmd_rd = rd[4:0]; cmd_rs1 = rs1[4:0]; cmd_rs2 = rs2[4:0];
            cmd_imm = imm[20:0]; cmd_last = last; cmd_valid = 1'b1;
            @(posedge clk);
            #1 cmd_valid = 1'b0;
            cmd_last = 1'b0;
            acc = 1'b1;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
      checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL reset_imem_we got=%b want=0", imem_we); end
      checks++; if (imem_addr !== '0) begin errors++; $display("FAIL reset_imem_addr got=%0d want=0", imem_addr); end
      checks++; if (imem_wdata !== 32'h0) begin errors++; $display("FAIL reset_imem_wdata got=%h want=0", imem_wdata); end
      checks++; if (words_written !== '0) begin errors++; $display("FAIL reset_words got=%0d want=0", words_written); end
      checks++; if (cpu_run !== 1'b0) begin errors++; $display("FAIL reset_cpu_run got=%b want=0", cpu_run); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", err); end
      checks++; if (err_code !== 2'b00) begin errors++; $display("FAIL reset_err_code got=%b want=00", err_code); end
   endtask

   task automatic test_add();
      bit acc;
      do_reset();
      send_cmd(0, 3, 1, 2, 0, 1'b0, acc);
      checks++; if (!acc) begin errors++; $display("FAIL add_accept got=0 want=1"); end
      @(negedge clk);
      checks++; if (imem_we !== 1'b1) begin errors++; $display("FAIL add_we got=%b want=1", imem_we); end
      checks++; if (imem_addr !== 2'd0) begin errors++; $display("FAIL add_addr got=%0d want=0", imem_addr); end
      checks++; if (imem_wdata !== 32'h002081B3) begin errors++; $display("FAIL add_word got=%h want=002081b3", imem_wdata); end
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL add_ready_in_write got=%b want=0", cmd_ready); end
      @(negedge clk);
      checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL add_we_one_cycle got=%b want=0", imem_we); end
      checks++; if (words_written !== 3'd1) begin errors++; $display("FAIL add_words got=%0d want=1", words_written); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      @(negedge clk);
      cmd_op = 4'd5; cmd_rd = 5'd1; cmd_rs1 = 5'd0; cmd_rs2 = 5'd0; cmd_imm = 21'd5; cmd_valid = 1'b1;
      @(negedge clk);
      checks++; if (imem_we !== 1'b1 || imem_addr !== 2'd0 || imem_wdata !== 32'h00500093) begin
         errors++; $display("FAIL b2b_addi got we=%b addr=%0d data=%h want we=1 addr=0 data=00500093", imem_we, imem_addr, imem_wdata); end
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_write1 got=%b want=0", cmd_ready); end
      cmd_op = 4'd1; cmd_rd = 5'd5; cmd_rs1 = 5'd6; cmd_rs2 = 5'd7; cmd_imm = 21'd0;
      @(negedge clk);
      checks++; if (cmd_ready !== 1'b1 || imem_we !== 1'b0) begin
         errors++; $display("FAIL b2b_idle got ready=%b we=%b want ready=1 we=0", cmd_ready, imem_we); end
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++; if (imem_we !== 1'b1 || imem_addr !== 2'd1 || imem_wdata !== 32'h407302B3) begin
         errors++; $display("FAIL b2b_sub got we=%b addr=%0d data=%h want we=1 addr=1 data=407302b3", imem_we, imem_addr, imem_wdata); end
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_write2 got=%b want=0", cmd_ready); end
      @(negedge clk);
      checks++; if (words_written !== 3'd2) begin errors++; $display("FAIL b2b_words got=%0d want=2", words_written); end
   endtask

   task automatic test_beq_range();
      bit acc;
      do_reset();
      send_cmd(8, 0, 1, 2, 8, 1'b0, acc);
      @(negedge clk);
      checks++; if (imem_we !== 1'b1 || imem_wdata !== 32'h00208463) begin
         errors++; $display("FAIL beq_word got we=%b data=%h want we=1 data=00208463", imem_we, imem_wdata); end
      send_cmd(8, 0, 1, 2, 7, 1'b0, acc);
      @(negedge clk);
      #1;
      checks++; if (err !== 1'b1 || err_code !== 2'b10) begin
         errors++; $display("FAIL beq_odd_err got err=%b code=%b want err=1 code=10", err, err_code); end
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL beq_err_ready got=%b want=0", cmd_ready); end
      checks++; if (wr_data_q.size() != 1) begin errors++; $display("FAIL beq_err_writes got=%0d want=1", wr_data_q.size()); end
      do_restart();
      checks++; if (err !== 1'b0 || words_written !== '0 || err_code !== 2'b00 || cmd_ready !== 1'b1) begin
         errors++; $display("FAIL beq_restart got err=%b words=%0d code=%b ready=%b want 0 0 00 1", err, words_written, err_code, cmd_ready); end
   endtask

   task automatic test_illegal();
      bit acc;
      do_reset();
      send_cmd(12, 1, 1, 1, 0, 1'b1, acc);
      @(negedge clk);
      #1;
      checks++; if (err !== 1'b1 || err_code !== 2'b01) begin
         errors++; $display("FAIL illegal_code got err=%b code=%b want err=1 code=01", err, err_code); end
      checks++; if (cpu_run !== 1'b0) begin errors++; $display("FAIL illegal_last_run got=%b want=0", cpu_run); end
      cmd_op = 4'd0; cmd_valid = 1'b1;
      repeat (5) @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      checks++; if (wr_data_q.size() != 0 || words_written !== '0) begin
         errors++; $display("FAIL illegal_hold_writes got writes=%0d words=%0d want 0 0", wr_data_q.size(), words_written); end
      checks++; if (err_code !== 2'b01 || cmd_ready !== 1'b0) begin
         errors++; $display("FAIL illegal_hold_state got code=%b ready=%b want 01 0", err_code, cmd_ready); end
   endtask

   task automatic test_full_program();
      bit acc;
      do_reset();
      for (int i = 0; i < DEPTH; i++) send_cmd(5, i + 1, i, 0, i * 3 - 2, (i == DEPTH - 1), acc);
      repeat (3) @(negedge clk);
      #1;
      checks++; if (cpu_run !== 1'b1 || err !== 1'b0 || words_written !== 3'd4) begin
         errors++; $display("FAIL full_done got run=%b err=%b words=%0d want 1 0 4", cpu_run, err, words_written); end
      checks++; if (wr_data_q.size() != DEPTH) begin errors++; $display("FAIL full_writes got=%0d want=%0d", wr_data_q.size(), DEPTH); end
      for (int i = 0; i < DEPTH && i < wr_data_q.size(); i++) begin
         checks++;
         if (wr_addr_q[i] != i || wr_data_q[i] !== ref_word(5, i + 1, i, 0, i * 3 - 2)) begin
            errors++; $display("FAIL full_word%0d got addr=%0d data=%h want addr=%0d data=%h", i, wr_addr_q[i], wr_data_q[i], i, ref_word(5, i + 1, i, 0, i * 3 - 2)); end
      end
      do_reset();
      for (int i = 0; i < DEPTH; i++) send_cmd(0, 1, 2, 3, 0, 1'b0, acc);
      send_cmd(0, 1, 2, 3, 0, 1'b0, acc);
      checks++; if (!acc) begin errors++; $display("FAIL overflow_accept got=0 want=1"); end
      repeat (3) @(negedge clk);
      #1;
      checks++; if (err !== 1'b1 || err_code !== 2'b11 || cpu_run !== 1'b0) begin
         errors++; $display("FAIL overflow_code got err=%b code=%b run=%b want 1 11 0", err, err_code, cpu_run); end
      checks++; if (wr_data_q.size() != DEPTH || words_written !== 3'd4) begin
         errors++; $display("FAIL overflow_writes got writes=%0d words=%0d want 4 4", wr_data_q.size(), words_written); end
   endtask

   task automatic test_short_program();
      bit acc;
      do_reset();
      send_cmd(4, 1, 2, 3, 0, 1'b0, acc);
      send_cmd(2, 4, 5, 6, 0, 1'b1, acc);
      @(negedge clk);
      checks++; if (imem_we !== 1'b1 || imem_addr !== 2'd1) begin
         errors++; $display("FAIL short_write2 got we=%b addr=%0d want 1 1", imem_we, imem_addr); end
`ifdef NOP_PAD_EN
      for (int a = 2; a < DEPTH; a++) begin
         @(negedge clk);
         checks++; if (imem_we !== 1'b1 || imem_addr !== a[ADDR_W-1:0] || imem_wdata !== 32'h00000013 || cpu_run !== 1'b0) begin
            errors++; $display("FAIL short_pad%0d got we=%b addr=%0d data=%h run=%b want 1 %0d 00000013 0", a, imem_we, imem_addr, imem_wdata, cpu_run, a); end
      end
      @(negedge clk);
      checks++; if (cpu_run !== 1'b1 || imem_we !== 1'b0 || words_written !== 3'd4) begin
         errors++; $display("FAIL short_pad_done got run=%b we=%b words=%0d want 1 0 4", cpu_run, imem_we, words_written); end
`else
      @(negedge clk);
      checks++; if (cpu_run !== 1'b1 || imem_we !== 1'b0 || words_written !== 3'd2) begin
         errors++; $display("FAIL short_done got run=%b we=%b words=%0d want 1 0 2", cpu_run, imem_we, words_written); end
      repeat (3) @(negedge clk);
      #1;
      checks++; if (wr_data_q.size() != 2) begin errors++; $display("FAIL short_no_pad got writes=%0d want=2", wr_data_q.size()); end
`endif
   endtask

   task automatic test_reset_mid_op();
      bit acc;
      int n;
      do_reset();
      send_cmd(0, 1, 1, 1, 0, 1'b0, acc);
      send_cmd(0, 2, 2, 2, 0, 1'b1, acc);
      @(negedge clk);
`ifdef NOP_PAD_EN
      @(negedge clk);
`endif
      #2 rst_n = 1'b0;
      #1;
      checks++; if (imem_we !== 1'b0 || cmd_ready !== 1'b1 || words_written !== '0 || imem_addr !== '0
                    || imem_wdata !== 32'h0 || cpu_run !== 1'b0) begin
         errors++; $display("FAIL midreset_outputs got we=%b ready=%b words=%0d addr=%0d data=%h run=%b want 0 1 0 0 0 0",
                            imem_we, cmd_ready, words_written, imem_addr, imem_wdata, cpu_run); end
      n = wr_data_q.size();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      checks++; if (wr_data_q.size() != n || cpu_run !== 1'b0 || words_written !== '0) begin
         errors++; $display("FAIL midreset_abandon got writes=%0d run=%b words=%0d want %0d 0 0", wr_data_q.size(), cpu_run, words_written, n); end
   endtask

   task automatic test_random();
      int bvals[12] = '{2047, -2048, 2048, -2049, 4094, -4096, 4096, 4095, -1048576, 1048574, 1048575, -1};
      int          exp_a[$];
      logic [31:0] exp_d[$];
      int len, op, rd, rs1, rs2, imm, code, exp_count, exp_code;
      bit last, acc, exp_run;
      for (int p = 0; p < 40; p++) begin
         do_restart();
         len = $urandom_range(1, 5);
         exp_count = 0; exp_code = 0; exp_run = 1'b0;
         exp_a.delete(); exp_d.delete();
         for (int i = 0; i < len; i++) begin
            op  = ($urandom_range(0, 9) == 0) ? $urandom_range(11, 15) : $urandom_range(0, 10);
            rd  = $urandom_range(0, 31); rs1 = $urandom_range(0, 31); rs2 = $urandom_range(0, 31);
            case ($urandom_range(0, 3))
               0: imm = $urandom_range(0, 4095) - 2048;
               1: imm = $urandom_range(0, 8191) - 4096;
               2: imm = $urandom_range(0, 2097151) - 1048576;
               default: imm = bvals[$urandom_range(0, 11)];
            endcase
            last = (i == len - 1);
            code = ref_check(op, imm);
            if (code == 0 && exp_count == DEPTH) code = 3;
            send_cmd(op, rd, rs1, rs2, imm, last, acc);
            checks++; if (!acc) begin errors++; $display("FAIL rand%0d_accept timeout cmd=%0d", p, i); end
            if (code != 0) begin exp_code = code; break; end
            exp_a.push_back(exp_count);
            exp_d.push_back(ref_word(op, rd, rs1, rs2, imm));
            exp_count++;
            if (last) exp_run = 1'b1;
         end
`ifdef NOP_PAD_EN
         if (exp_run) while (exp_count < DEPTH) begin exp_a.push_back(exp_count); exp_d.push_back(32'h13); exp_count++; end
`endif
         repeat (8) @(negedge clk);
         #1;
         checks++; if (int'(words_written) != exp_count || cpu_run !== exp_run || err !== (exp_code != 0) || int'(err_code) != exp_code) begin
            errors++; $display("FAIL rand%0d_status got words=%0d run=%b err=%b code=%0d want %0d %b %b %0d",
                               p, words_written, cpu_run, err, err_code, exp_count, exp_run, (exp_code != 0), exp_code); end
         checks++; if (wr_data_q.size() != exp_d.size()) begin
            errors++; $display("FAIL rand%0d_nwrites got=%0d want=%0d", p, wr_data_q.size(), exp_d.size()); end
         for (int k = 0; k < exp_d.size() && k < wr_data_q.size(); k++) begin
            checks++;
            if (wr_addr_q[k] != exp_a[k] || wr_data_q[k] !== exp_d[k]) begin
               errors++; $display("FAIL rand%0d_word%0d got addr=%0d data=%h want addr=%0d data=%h", p, k, wr_addr_q[k], wr_data_q[k], exp_a[k], exp_d[k]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_back_to_back();
      test_beq_range();
      test_illegal();
      test_full_program();
      test_short_program();
      test_reset_mid_op();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1);
   end

endmodule
`default_nettype wire
